// File: rtl/wfg_wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
`timescale 1ns/1ps
package wfg_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Read data returned to a master whose slave access was force-terminated.
    localparam logic [31:0] WFG_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/wfg_wb_arb_watchdog.sv
// Stall counter for the granted slave access: counts stb-without-ack cycles
// and raises tc while the count sits at TIMEOUT_CYCLES.
`timescale 1ns/1ps
module wfg_wb_arb_watchdog
    import wfg_wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic clr,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(TIMEOUT_CYCLES));

    // Count stalled cycles; the terminal count itself acts as the ack that clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (stall) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wfg_wb_arbiter.sv
// Round-robin two-master Wishbone classic arbiter in front of wfg_top.
// Grant is registered and held for the whole cyc burst.
// Optional slave-hang watchdog: define WFG_WB_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module wfg_wb_arbiter
    import wfg_wb_arb_pkg::*;
#(
    parameter int BUSW           = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            io_wbs_clk,
    input  logic            io_wbs_rst_n,
    input  logic            m0_wbs_cyc,
    input  logic            m0_wbs_stb,
    input  logic            m0_wbs_we,
    input  logic [BUSW-1:0] m0_wbs_adr,
    input  logic [BUSW-1:0] m0_wbs_datwr,
    output logic [BUSW-1:0] m0_wbs_datrd,
    output logic            m0_wbs_ack,
    input  logic            m1_wbs_cyc,
    input  logic            m1_wbs_stb,
    input  logic            m1_wbs_we,
    input  logic [BUSW-1:0] m1_wbs_adr,
    input  logic [BUSW-1:0] m1_wbs_datwr,
    output logic [BUSW-1:0] m1_wbs_datrd,
    output logic            m1_wbs_ack,
    output logic            s_wbs_cyc,
    output logic            s_wbs_stb,
    output logic            s_wbs_we,
    output logic [BUSW-1:0] s_wbs_adr,
    output logic [BUSW-1:0] s_wbs_datwr,
    input  logic [BUSW-1:0] s_wbs_datrd,
    input  logic            s_wbs_ack,
    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    arb_state_t state, state_nxt;
    logic       last_gnt, last_gnt_nxt;   // 0: m0 was served last, 1: m1
    logic       req0, req1;
    logic       g0, g1;
    logic       stb_raw;                  // granted master's stb before any forcing
    logic       force_ack;

    assign req0    = m0_wbs_cyc & m0_wbs_stb;
    assign req1    = m1_wbs_cyc & m1_wbs_stb;
    assign g0      = (state == GNT0);
    assign g1      = (state == GNT1);
    assign gnt_o   = {g1, g0};
    assign stb_raw = (g0 & m0_wbs_stb) | (g1 & m1_wbs_stb);

    // State and round-robin history registers.
    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Arbitrate only from IDLE; a grant ends when its owner drops cyc.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_gnt)) state_nxt = GNT0;
                else if (req1)                   state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_wbs_cyc) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_wbs_cyc) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Route the owner's bus to the slave and the slave's response back to the owner.
    // Acks arriving after the owner dropped cyc are discarded.
    always_comb begin
        s_wbs_cyc    = 1'b0;
        s_wbs_stb    = 1'b0;
        s_wbs_we     = 1'b0;
        s_wbs_adr    = '0;
        s_wbs_datwr  = '0;
        m0_wbs_ack   = 1'b0;
        m1_wbs_ack   = 1'b0;
        m0_wbs_datrd = '0;
        m1_wbs_datrd = '0;
        if (g0) begin
            s_wbs_cyc    = m0_wbs_cyc;
            s_wbs_stb    = m0_wbs_stb & ~force_ack;
            s_wbs_we     = m0_wbs_we;
            s_wbs_adr    = m0_wbs_adr;
            s_wbs_datwr  = m0_wbs_datwr;
            m0_wbs_ack   = (s_wbs_ack & m0_wbs_cyc) | force_ack;
            m0_wbs_datrd = force_ack ? BUSW'(WFG_ARB_TIMEOUT_DATA) : s_wbs_datrd;
        end else if (g1) begin
            s_wbs_cyc    = m1_wbs_cyc;
            s_wbs_stb    = m1_wbs_stb & ~force_ack;
            s_wbs_we     = m1_wbs_we;
            s_wbs_adr    = m1_wbs_adr;
            s_wbs_datwr  = m1_wbs_datwr;
            m1_wbs_ack   = (s_wbs_ack & m1_wbs_cyc) | force_ack;
            m1_wbs_datrd = force_ack ? BUSW'(WFG_ARB_TIMEOUT_DATA) : s_wbs_datrd;
        end
    end

`ifdef WFG_WB_ARB_TIMEOUT_EN
    logic tc;

    wfg_wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (io_wbs_clk),
        .rst_n (io_wbs_rst_n),
        .stall (stb_raw & ~s_wbs_ack),
        .clr   (s_wbs_ack | ~(g0 | g1)),
        .tc    (tc)
    );

    // tc can linger for a cycle after the grant is released; only act while granted.
    assign force_ack = tc & (g0 | g1);

    // Sticky record that a slave access was ever force-terminated.
    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n)  timeout_o <= 1'b0;
        else if (force_ack) timeout_o <= 1'b1;
    end
`else
    logic unused_cfg;

    assign force_ack  = 1'b0;
    assign timeout_o  = 1'b0;
    assign unused_cfg = stb_raw ^ (TIMEOUT_CYCLES != 0);
`endif

endmodule
